// File: rtl/rolling_stats_if.sv
`default_nettype none
// ============================================================================
// Module      : rolling_stats_if
// Description : Sample/statistics bundle for rolling_stats.
//               master : producer of samples, consumer of statistics
//               slave  : the rolling_stats block itself
//   clear         flush the window (synchronous)
//   price_valid   price carries a new sample this cycle
//   price[7:0]    unsigned sample
//   N_mean[7:0]   floor mean of the last N samples
//   N_sqr_mean    floor mean of squares of the last N samples (16 bits)
//   current_data  newest sample, aligned with the two means
//   stats_valid   one-cycle pulse marking a coherent output set
//   window_full   high while N samples are held
// Revision    : 1.0  initial release
// ============================================================================
interface rolling_stats_if;
    logic        clear;
    logic        price_valid;
    logic [7:0]  price;
    logic [7:0]  N_mean;
    logic [15:0] N_sqr_mean;
    logic [7:0]  current_data;
    logic        stats_valid;
    logic        window_full;

    modport master (
        output clear, price_valid, price,
        input  N_mean, N_sqr_mean, current_data, stats_valid, window_full
    );

    modport slave (
        input  clear, price_valid, price,
        output N_mean, N_sqr_mean, current_data, stats_valid, window_full
    );
endinterface
`default_nettype wire

// File: rtl/rolling_stats.sv
`default_nettype none
// ============================================================================
// Module      : rolling_stats
// Description : Sliding-window mean and mean-of-squares over the last
//               N = 2^WINDOW_LOG2 accepted price samples.
//   clk   rising-edge clock
//   rst   synchronous active-high reset (priority over clear and samples)
//   bus   rolling_stats_if.slave (sample in, statistics out)
// Revision    : 1.0  initial release
// ============================================================================
module rolling_stats #(
    parameter int WINDOW_LOG2 = 3
) (
    input  wire logic         clk,
    input  wire logic         rst,
    rolling_stats_if.slave    bus
);
    localparam int c_N     = 1 << WINDOW_LOG2;
    localparam int c_SUM_W = 8 + WINDOW_LOG2;
    localparam int c_SQ_W  = 16 + WINDOW_LOG2;
    localparam int c_CNT_W = WINDOW_LOG2 + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_N - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [0:0] {
        ST_FILLING = 1'b0,
        ST_RUNNING = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [c_CNT_W-1:0]      r_count;
    logic [c_CNT_W-1:0]      w_count_nxt;
    logic [WINDOW_LOG2-1:0]  r_wr_ptr;
    logic [7:0]              r_buf [c_N];
    logic [c_SUM_W-1:0]      r_sum;
    logic [c_SQ_W-1:0]       r_sqsum;

    logic                    r_s1_full;
    logic [7:0]              r_s1_price;

    logic [7:0]              r_mean;
    logic [15:0]             r_sqmean;
    logic [7:0]              r_cur;
    logic                    r_stats_valid;

    logic                    w_accept;
    logic [7:0]              w_evicted;
    logic [15:0]             w_sq_new;
    logic [15:0]             w_sq_old;
    logic                    w_full_after;
    logic                    w_emit;

    // A sample presented together with clear is dropped.
    assign w_accept  = bus.price_valid & ~bus.clear;

    // While filling, the slot under the pointer holds stale data from an
    // earlier window, so nothing is subtracted.
    assign w_evicted = (r_state == ST_RUNNING) ? r_buf[r_wr_ptr] : 8'd0;
    assign w_sq_new  = {8'd0, bus.price} * {8'd0, bus.price};
    assign w_sq_old  = {8'd0, w_evicted} * {8'd0, w_evicted};

    // This sample either completes the first full window or slides it.
    assign w_full_after = w_accept &&
                          ((r_state == ST_RUNNING) || (r_count == c_CNT_LAST));

    // Clear kills the sample currently sitting in stage 1.
    assign w_emit = r_s1_full & ~bus.clear;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FILLING;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        if (bus.clear) begin
            w_state_nxt = ST_FILLING;
            w_count_nxt = '0;
        end else if (bus.price_valid && (r_state == ST_FILLING)) begin
            w_count_nxt = r_count + c_CNT_ONE;
            if (r_count == c_CNT_LAST) begin
                w_state_nxt = ST_RUNNING;
            end
        end
    end

    // ---------------------------------------------- sample storage (no reset)
    always_ff @(posedge clk) begin
        if (!rst && w_accept) begin
            r_buf[r_wr_ptr] <= bus.price;
        end
    end

    // ------------------------------------------------ stage 1: running sums
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_sum      <= '0;
            r_sqsum    <= '0;
            r_s1_full  <= 1'b0;
            r_s1_price <= 8'd0;
        end else begin
            r_s1_full <= w_full_after;
            if (bus.clear) begin
                r_wr_ptr <= '0;
                r_sum    <= '0;
                r_sqsum  <= '0;
            end else if (w_accept) begin
                r_wr_ptr   <= r_wr_ptr + 1'b1;
                r_sum      <= r_sum + c_SUM_W'(bus.price) - c_SUM_W'(w_evicted);
                r_sqsum    <= r_sqsum + c_SQ_W'(w_sq_new) - c_SQ_W'(w_sq_old);
                r_s1_price <= bus.price;
            end
        end
    end

    // ------------------------------------------- stage 2: published results
    // Dividing by N is a plain shift; the upper bits are exactly the floor.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mean        <= 8'd0;
            r_sqmean      <= 16'd0;
            r_cur         <= 8'd0;
            r_stats_valid <= 1'b0;
        end else begin
            r_stats_valid <= w_emit;
            if (w_emit) begin
                r_mean   <= r_sum[c_SUM_W-1:WINDOW_LOG2];
                r_sqmean <= r_sqsum[c_SQ_W-1:WINDOW_LOG2];
                r_cur    <= r_s1_price;
            end
        end
    end

    assign bus.N_mean       = r_mean;
    assign bus.N_sqr_mean   = r_sqmean;
    assign bus.current_data = r_cur;
    assign bus.stats_valid  = r_stats_valid;
    assign bus.window_full  = (r_state == ST_RUNNING);

endmodule
`default_nettype wire

// File: tb/tb_rolling_stats.sv
`default_nettype none
// ============================================================================
// Module      : tb_rolling_stats
// Description : Scoreboard bench for rolling_stats (N = 8). The driver feeds
//               samples and pushes expected statistics computed from a queue
//               of the last accepted samples; a negedge monitor pops and
//               compares whenever stats_valid is seen.
// Revision    : 1.0  initial release
// ============================================================================
module tb_rolling_stats;
    localparam int c_WL = 3;
    localparam int c_N  = 8;

    typedef struct {
        int          due;
        logic [7:0]  mean;
        logic [15:0] sq;
        logic [7:0]  cur;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    bit   started;
    int   n_cmp;
    int   n_bad;

    exp_t q[$];
    int   win[$];
    exp_t me;

    logic [7:0]  held_mean;
    logic [15:0] held_sq;
    logic [7:0]  held_cur;

    rolling_stats_if bus();

    rolling_stats #(.WINDOW_LOG2(c_WL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Apply one cycle of stimulus and update the reference window.
    task automatic drive(input bit pv, input int p, input bit clr, input bit r);
        int   k;
        int   s;
        int   ss;
        exp_t e;
        k = cyc;
        bus.price_valid = pv;
        bus.price       = 8'(p);
        bus.clear       = clr;
        rst             = r;
        if (r || clr) begin
            // The sample accepted last cycle never gets published.
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].due == k + 1) q.delete(i);
            end
            win.delete();
        end else if (pv) begin
            win.push_back(p & 255);
            if (win.size() > c_N) win.delete(0);
            if (win.size() == c_N) begin
                s  = 0;
                ss = 0;
                foreach (win[i]) begin
                    s  += win[i];
                    ss += win[i] * win[i];
                end
                e.due  = k + 2;
                e.mean = 8'(s / c_N);
                e.sq   = 16'(ss / c_N);
                e.cur  = 8'(p);
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (started) begin
            if (bus.stats_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_valid", 32'(bus.stats_valid), 0);
                end else begin
                    me = q.pop_front();
                    chk("valid_cycle", 32'(cyc), 32'(me.due));
                    chk("N_mean", 32'(bus.N_mean), 32'(me.mean));
                    chk("N_sqr_mean", 32'(bus.N_sqr_mean), 32'(me.sq));
                    chk("current_data", 32'(bus.current_data), 32'(me.cur));
                    chk("variance_nonneg",
                        32'((32'(bus.N_mean) * 32'(bus.N_mean)) <= 32'(bus.N_sqr_mean)), 1);
                    held_mean = me.mean;
                    held_sq   = me.sq;
                    held_cur  = me.cur;
                end
            end else begin
                if (q.size() > 0 && q[0].due <= cyc) begin
                    me = q.pop_front();
                    chk("missing_valid", 32'(bus.stats_valid), 1);
                end
                chk("hold_mean", 32'(bus.N_mean), 32'(held_mean));
                chk("hold_sqr", 32'(bus.N_sqr_mean), 32'(held_sq));
                chk("hold_cur", 32'(bus.current_data), 32'(held_cur));
            end
            if (rst) begin
                held_mean = 8'd0;
                held_sq   = 16'd0;
                held_cur  = 8'd0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        started = 1'b0;
        held_mean = 8'd0;
        held_sq = 16'd0;
        held_cur = 8'd0;
        rst = 1'b1;
        bus.clear = 1'b0;
        bus.price_valid = 1'b0;
        bus.price = 8'd0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        chk("rst_N_mean", 32'(bus.N_mean), 0);
        chk("rst_N_sqr_mean", 32'(bus.N_sqr_mean), 0);
        chk("rst_current_data", 32'(bus.current_data), 0);
        chk("rst_stats_valid", 32'(bus.stats_valid), 0);
        chk("rst_window_full", 32'(bus.window_full), 0);
        started = 1'b1;
        drive(0, 0, 0, 1);
        idle(2);

        // Fill with 100s, then one eviction with 108
        for (int i = 0; i < 8; i++) drive(1, 100, 0, 0);
        idle(3);
        chk("fill_window_full", 32'(bus.window_full), 1);
        drive(1, 108, 0, 0);
        idle(3);

        // Underfill: 7 x 255 never completes a window
        drive(0, 0, 0, 1);
        for (int i = 0; i < 7; i++) drive(1, 255, 0, 0);
        idle(10);
        chk("underfill_window_full", 32'(bus.window_full), 0);

        // Full scale
        drive(0, 0, 0, 1);
        for (int i = 0; i < 8; i++) drive(1, 255, 0, 0);
        idle(3);

        // Clear on the 5th sample of a 200 stream, then 8 x 10
        for (int i = 0; i < 4; i++) drive(1, 200, 0, 0);
        drive(1, 200, 1, 0);
        chk("clear_window_full", 32'(bus.window_full), 0);
        for (int i = 0; i < 8; i++) drive(1, 10, 0, 0);
        idle(3);
        chk("clear_refill_full", 32'(bus.window_full), 1);

        // Ramp with gaps and a reset on the 12th sample
        drive(0, 0, 0, 1);
        for (int v = 0; v < 20; v++) begin
            repeat ($urandom_range(0, 2)) drive(0, $urandom_range(0, 255), 0, 0);
            drive(1, v, 0, (v == 11) ? 1'b1 : 1'b0);
        end
        idle(3);

        // Randomised traffic with occasional clear and reset
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 99) < 75) ? 1'b1 : 1'b0,
                  $urandom_range(0, 255),
                  ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
        end
        idle(4);
        chk("scoreboard_drained", 32'(q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/rolling_stats.md
ROLLING_STATS -- requirements
Module: rolling_stats

Interface
REQ-001 SHALL have parameter WINDOW_LOG2, default 3, window length N = 2^WINDOW_LOG2 samples (legal 1..6).
REQ-002 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port clear  input  1  synchronous window flush.
REQ-005 SHALL have port price_valid  input  1  price carries a new sample this cycle.
REQ-006 SHALL have port price  input  8  unsigned price sample.
REQ-007 SHALL have port N_mean  output  8  floor mean of the last N samples.
REQ-008 SHALL have port N_sqr_mean  output  16  floor mean of the squares of the last N samples.
REQ-009 SHALL have port current_data  output  8  newest sample, aligned with N_mean/N_sqr_mean.
REQ-010 SHALL have port stats_valid  output  1  one-cycle pulse; all three data outputs are a coherent set.
REQ-011 SHALL have port window_full  output  1  high while N samples are held.

Function
REQ-012 SHALL hold the last N samples in an N-entry circular buffer with a WINDOW_LOG2-bit write pointer that wraps from N-1 to 0.
REQ-013 SHALL keep a running sum of (8+WINDOW_LOG2) bits and a running sum of squares of (16+WINDOW_LOG2) bits; no overflow is possible at any legal N.
REQ-014 SHALL, on an accepted sample, compute evicted = buffer[wr_ptr] when in RUNNING and 0 when in FILLING.
REQ-015 SHALL, in the same cycle, update sum <= sum + price - evicted and sqsum <= sqsum + price*price - evicted*evicted, write price to buffer[wr_ptr], and advance wr_ptr.
REQ-016 SHALL implement FSM FILLING -> RUNNING, with a fill counter 0..N.
REQ-017 SHALL move from FILLING to RUNNING on the accept that makes the count N; the count saturates at N in RUNNING.
REQ-018 SHALL assert window_full exactly while in RUNNING, registered.
REQ-019 SHALL use a two-stage pipeline. Stage 1 (accept cycle) updates the buffer and sums and registers price plus a flag "window full after this sample". Stage 2 registers N_mean = sum >> WINDOW_LOG2, N_sqr_mean = sqsum >> WINDOW_LOG2, current_data = stage-1 price, and stats_valid = stage-1 flag.
REQ-020 SHALL assert stats_valid exactly 2 cycles after a price_valid cycle, and only if that sample completed or extended a full window.
REQ-021 SHALL produce no stats_valid for the first N-1 samples after reset or clear.
REQ-022 SHALL hold N_mean, N_sqr_mean and current_data stable between stats_valid pulses.
REQ-023 SHALL accept back-to-back samples every cycle with no stall.
REQ-024 SHALL guarantee N_mean*N_mean <= N_sqr_mean on every stats_valid, so the downstream variance is non-negative; this follows from floor truncation.
REQ-025 SHALL, on clear, zero sum, sqsum, fill count and wr_ptr, return to FILLING, and drop a sample presented in the same cycle.
REQ-026 SHALL let a clear suppress any stats_valid for a sample in flight in stage 1 that cycle.
REQ-027 SHALL not require buffer contents to be cleared, because stale entries are never read in FILLING.
REQ-028 SHALL ignore price while price_valid is low and leave all state unchanged.

Reset
REQ-029 SHALL, on rst, set FILLING, count=0, wr_ptr=0, sum=0, sqsum=0, N_mean=0, N_sqr_mean=0, current_data=0, stats_valid=0, window_full=0.
REQ-030 SHALL give rst priority over clear and price_valid.
REQ-031 SHALL, when rst is asserted mid-stream, produce no stats_valid in the following two cycles.

Verification (N=8)
REQ-032 SHALL be verified for fill: 8 consecutive samples of 100 -> stats_valid only 2 cycles after the 8th, N_mean=100, N_sqr_mean=10000, current_data=100, window_full=1.
REQ-033 SHALL be verified for eviction: after REQ-032, one sample of 108 -> N_mean=101, N_sqr_mean=10208, current_data=108.
REQ-034 SHALL be verified for underfill: 7 samples of 255, then idle 10 cycles -> no stats_valid, window_full=0.
REQ-035 SHALL be verified for full-scale: 8 samples of 255 -> N_mean=255, N_sqr_mean=65025.
REQ-036 SHALL be verified for clear: clear on the 5th sample cycle of a stream of 200s, then 8 samples of 10 -> first stats_valid with N_mean=10, N_sqr_mean=100.
REQ-037 SHALL be verified for wrap and gaps: ramp 0..19 with random price_valid gaps and a rst at the 12th sample -> stats equal a floor-mean model over the last 8 accepted samples, with no pulse within 2 cycles of rst.
